mont_iter_core: RTL and testbench

MONT_ITER_CORE -- requirements
Module: mont_iter_core

---
 rtl/mont_iter_core.sv | 118 +++++++++++
 tb/tb_mont_iter_core.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/mont_iter_core.sv
// Bit-serial Montgomery multiplier: S = A*B*2^-k (mod M), left in [0, 2M).
// Exposes S, S-M and the select for a downstream final-subtraction mux.
module mont_iter_core #(
    parameter int K_BITS = 256
) (
    input  logic              i_Clk,
    input  logic              i_Rst_n,
    input  logic              i_Start,
    input  logic [K_BITS-1:0] i_A,
    input  logic [K_BITS-1:0] i_B,
    input  logic [K_BITS-1:0] i_M,
    output logic [K_BITS:0]   o_S,
    output logic [K_BITS:0]   o_D,
    output logic              o_Sel,
    output logic              o_Busy,
    output logic              o_Done
);

    // state   | meaning
    // IDLE    | waiting for i_Start; operands latched on the accepting edge
    // ITER    | one multiplier bit per cycle, K_BITS cycles
    // SUB     | register S, S-M and the no-borrow select
    // DONE    | one-cycle result-valid pulse

    localparam int CW = (K_BITS > 1) ? $clog2(K_BITS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ITER = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_r, state_nxt;

    logic [K_BITS-1:0] a_sh;
    logic [K_BITS-1:0] b_r;
    logic [K_BITS-1:0] m_r;
    logic [K_BITS:0]   s_r;
    logic [CW-1:0]     i_r;

    logic              last_iter;
    logic              a_bit;
    logic              q_bit;
    logic [K_BITS+1:0] sum;
    logic [K_BITS+1:0] diff;

    // A is shifted right each iteration so bit i always sits at position 0
    assign a_bit     = a_sh[0];
    assign q_bit     = s_r[0] ^ (a_bit & b_r[0]);
    assign sum       = {1'b0, s_r}
                     + (a_bit ? {2'b00, b_r} : '0)
                     + (q_bit ? {2'b00, m_r} : '0);
    assign diff      = {1'b0, s_r} - {2'b00, m_r};
    assign last_iter = (i_r == CW'(K_BITS - 1));

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: if (i_Start) state_nxt = ST_ITER;
            ST_ITER: if (last_iter) state_nxt = ST_SUB;
            ST_SUB:  state_nxt = ST_DONE;
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        o_Busy = (state_r != ST_IDLE);
        o_Done = (state_r == ST_DONE);
    end

    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            a_sh  <= '0;
            b_r   <= '0;
            m_r   <= '0;
            s_r   <= '0;
            i_r   <= '0;
            o_S   <= '0;
            o_D   <= '0;
            o_Sel <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (i_Start) begin
                        a_sh <= i_A;
                        b_r  <= i_B;
                        m_r  <= i_M;
                        s_r  <= '0;
                        i_r  <= '0;
                    end
                end
                ST_ITER: begin
                    s_r  <= sum[K_BITS+1:1];
                    a_sh <= a_sh >> 1;
                    // hold on the final iteration so the counter never wraps
                    if (!last_iter) i_r <= i_r + 1'b1;
                end
                ST_SUB: begin
                    o_S   <= s_r;
                    o_D   <= diff[K_BITS:0];
                    o_Sel <= ~diff[K_BITS+1];
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_iter_core.sv
// Directed and random checks of mont_iter_core with K_BITS=8, M=239.
module tb_mont_iter_core;

    localparam int K  = 8;
    localparam int MV = 239;

    logic         i_Clk;
    logic         i_Rst_n;
    logic         i_Start;
    logic [K-1:0] i_A;
    logic [K-1:0] i_B;
    logic [K-1:0] i_M;
    logic [K:0]   o_S;
    logic [K:0]   o_D;
    logic         o_Sel;
    logic         o_Busy;
    logic         o_Done;

    mont_iter_core #(.K_BITS(K)) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Start (i_Start),
        .i_A     (i_A),
        .i_B     (i_B),
        .i_M     (i_M),
        .o_S     (o_S),
        .o_D     (o_D),
        .o_Sel   (o_Sel),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done)
    );

    initial i_Clk = 1'b0;
    always #5 i_Clk = ~i_Clk;

    typedef struct {
        logic [K-1:0] a;
        logic [K-1:0] b;
        int           exp_mux;
    } vec_t;

    vec_t vecs[8];

    int n_chk  = 0;
    int n_fail = 0;

    int res_mux, res_s, res_d, res_sel;
    int done_at, done_cnt, busy_lo;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Start one run; optionally re-pulse i_Start with other operands at
    // cycle repulse, or pull reset low at cycle rst_cyc.
    task automatic run_op(input logic [K-1:0] a, input logic [K-1:0] b,
                          input int repulse, input int rst_cyc);
        @(negedge i_Clk);
        i_A = a;
        i_B = b;
        i_Start = 1'b1;
        done_at = 0;
        done_cnt = 0;
        busy_lo = 0;
        res_mux = -1;
        res_s = -1;
        res_d = -1;
        res_sel = -1;
        for (int c = 1; c <= 16; c++) begin
            @(negedge i_Clk);
            if (o_Done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
                res_s   = int'(o_S);
                res_d   = int'(o_D);
                res_sel = int'(o_Sel);
                res_mux = o_Sel ? int'(o_D) : int'(o_S);
            end
            if (!o_Busy && busy_lo == 0) busy_lo = c;
            i_Start = 1'b0;
            if (repulse != 0 && c == repulse) begin
                i_A = 8'd17;
                i_B = 8'd1;
                i_Start = 1'b1;
            end
            if (rst_cyc != 0 && c == rst_cyc) begin
                i_Rst_n = 1'b0;
                #1;
                check("rst_mid_S",    int'(o_S),    0);
                check("rst_mid_D",    int'(o_D),    0);
                check("rst_mid_Sel",  int'(o_Sel),  0);
                check("rst_mid_Busy", int'(o_Busy), 0);
                check("rst_mid_Done", int'(o_Done), 0);
            end
            if (rst_cyc != 0 && c == rst_cyc + 1) i_Rst_n = 1'b1;
        end
    endtask

    initial begin
        int a, b, exp, d1, d2;

        vecs[0] = '{8'd5,   8'd7,   227};
        vecs[1] = '{8'd0,   8'd100, 0};
        vecs[2] = '{8'd17,  8'd1,   1};
        vecs[3] = '{8'd1,   8'd1,   225};
        vecs[4] = '{8'd238, 8'd238, 225};
        vecs[5] = '{8'd255, 8'd238, 224};
        vecs[6] = '{8'd128, 8'd2,   1};
        vecs[7] = '{8'd16,  8'd15,  225};

        i_Rst_n = 1'b0;
        i_Start = 1'b0;
        i_A = '0;
        i_B = '0;
        i_M = 8'(MV);
        repeat (3) @(negedge i_Clk);
        check("reset_S",    int'(o_S),    0);
        check("reset_D",    int'(o_D),    0);
        check("reset_Sel",  int'(o_Sel),  0);
        check("reset_Busy", int'(o_Busy), 0);
        check("reset_Done", int'(o_Done), 0);
        i_Rst_n = 1'b1;

        for (int v = 0; v < 8; v++) begin
            run_op(vecs[v].a, vecs[v].b, 0, 0);
            check($sformatf("vec%0d_mux", v), res_mux, vecs[v].exp_mux);
            check($sformatf("vec%0d_done_cnt", v), done_cnt, 1);
            if (v == 0) begin
                check("done_latency", done_at, K + 2);
                check("busy_window",  busy_lo, K + 3);
            end
            if (v == 1) begin
                check("zero_S",   res_s,   0);
                check("zero_Sel", res_sel, 0);
                check("zero_D",   res_d,   273);
            end
        end

        // second start mid-run must be ignored
        run_op(8'd5, 8'd7, 3, 0);
        check("repulse_mux",      res_mux,  227);
        check("repulse_done_cnt", done_cnt, 1);

        // reset mid-run aborts with no done pulse, then a clean run
        run_op(8'd5, 8'd7, 0, 4);
        check("rst_abort_done_cnt", done_cnt, 0);
        run_op(8'd5, 8'd7, 0, 0);
        check("after_rst_mux", res_mux, 227);

        // held start: back-to-back runs every K+3 cycles
        @(negedge i_Clk);
        i_A = 8'd5;
        i_B = 8'd7;
        i_Start = 1'b1;
        d1 = 0;
        d2 = 0;
        res_mux = -1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge i_Clk);
            if (o_Done) begin
                if (d1 == 0) d1 = c;
                else if (d2 == 0) d2 = c;
                res_mux = o_Sel ? int'(o_D) : int'(o_S);
            end
        end
        i_Start = 1'b0;
        check("held_first_done",  d1, K + 2);
        check("held_second_done", d2, 2 * K + 5);
        check("held_mux",         res_mux, 227);
        repeat (16) @(negedge i_Clk);

        for (int r = 0; r < 24; r++) begin
            a = int'($urandom_range(255, 0));
            b = int'($urandom_range(MV - 1, 0));
            exp = (a * b * 225) % MV;
            run_op(8'(a), 8'(b), 0, 0);
            check($sformatf("rand%0d_mux(a=%0d,b=%0d)", r, a, b), res_mux, exp);
            check($sformatf("rand%0d_S_lt_2M", r), int'(res_s < 2 * MV), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
